// File: rtl/sat_add_pkg.sv
// Shared defaults, saturation bound helpers and the stage-1 record layout
// for the shared saturating-adder arbiter.
package sat_add_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 4;
    localparam int CNT_W_DEF = 8;
    localparam int IDW_DEF   = $clog2(N_REQ_DEF);

    // Largest representable value of a w-bit two's complement number.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative representable value of a w-bit two's complement number.
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    // Operand record held in stage 1 at the default widths. The top module
    // builds the same layout at its own parameter widths.
    typedef struct packed {
        logic [W_DEF-1:0]   a;
        logic [W_DEF-1:0]   b;
        logic [IDW_DEF-1:0] id;
    } s1_t;

endpackage

// File: rtl/sat_add_core.sv
// Combinational W-bit signed saturating adder: one guard bit catches the
// overflow, then the sum is clamped to the representable range.
module sat_add_core
    import sat_add_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    localparam int WE = W + 1;
    localparam logic signed [W:0] MAX_EXT = WE'(sat_max(W));
    localparam logic signed [W:0] MIN_EXT = WE'(sat_min(W));

    logic signed [W:0] ext;

    assign ext = $signed({a[W-1], a}) + $signed({b[W-1], b});

    // Clamp the widened sum to [min, max] and flag when clamping happened.
    always_comb begin
        sum = ext[W-1:0];
        sat = 1'b0;
        if (ext > MAX_EXT) begin
            sum = MAX_EXT[W-1:0];
            sat = 1'b1;
        end else if (ext < MIN_EXT) begin
            sum = MIN_EXT[W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter sharing one saturating adder among N_REQ lanes.
// Two pipeline registers (operand capture, result) advance together
// whenever the result slot is empty or being consumed.
module sat_add_arbiter
    import sat_add_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_vld,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_rdy,
    output logic               res_vld,
    input  logic               res_rdy,
    output logic [W-1:0]       res_sum,
    output logic [IDW-1:0]     res_id,
    output logic               res_sat,
    output logic [CNT_W-1:0]   sat_cnt,
    input  logic               sat_cnt_clr
);

    typedef struct packed {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [IDW-1:0] id;
    } s1_w_t;

    logic [W-1:0]     lane_a [N_REQ];
    logic [W-1:0]     lane_b [N_REQ];

    s1_w_t            s1_q, s1_d;
    logic             s1_vld_q, s1_vld_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic             res_vld_q, res_vld_d;
    logic [W-1:0]     res_sum_q, res_sum_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             res_sat_q, res_sat_d;
    logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    logic             adv;
    logic             found;
    logic [IDW-1:0]   grant;
    logic             accept;
    logic [W-1:0]     core_sum;
    logic             core_sat;
    logic             sat_evt;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign lane_a[gi] = req_a[gi*W +: W];
        assign lane_b[gi] = req_b[gi*W +: W];
    end

    // The whole pipe moves only when the result slot can take new data.
    assign adv    = !res_vld_q || res_rdy;
    assign accept = found && adv;

    // Search upward from the round-robin pointer for the first valid lane.
    always_comb begin
        logic [IDW-1:0] cand;
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % N_REQ);
            if (!found && req_vld[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    // Only the granted lane sees ready, and only when the pipe advances.
    always_comb begin
        req_rdy = '0;
        if (accept) begin
            req_rdy[grant] = 1'b1;
        end
    end

    sat_add_core #(
        .W (W)
    ) u_core (
        .a   (s1_q.a),
        .b   (s1_q.b),
        .sum (core_sum),
        .sat (core_sat)
    );

    // Next state of both pipe stages and the pointer, all gated by adv.
    always_comb begin
        s1_d      = s1_q;
        s1_vld_d  = s1_vld_q;
        rr_ptr_d  = rr_ptr_q;
        res_vld_d = res_vld_q;
        res_sum_d = res_sum_q;
        res_id_d  = res_id_q;
        res_sat_d = res_sat_q;
        if (adv) begin
            s1_vld_d = accept;
            if (accept) begin
                s1_d.a   = lane_a[grant];
                s1_d.b   = lane_b[grant];
                s1_d.id  = grant;
                rr_ptr_d = (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
            end
            res_vld_d = s1_vld_q;
            res_sum_d = core_sum;
            res_id_d  = s1_q.id;
            res_sat_d = core_sat;
        end
    end

    // A saturation event is a valid clamped result entering the output slot;
    // a clear in the same cycle still keeps that event.
    assign sat_evt = adv && s1_vld_q && core_sat;

    // Sticky saturation counter with clear; it parks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_cnt_clr) begin
            sat_cnt_d = sat_evt ? CNT_W'(1) : '0;
        end else if (sat_evt && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    // State registers; reset discards anything in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s1_vld_q  <= 1'b0;
            rr_ptr_q  <= '0;
            res_vld_q <= 1'b0;
            res_sum_q <= '0;
            res_id_q  <= '0;
            res_sat_q <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s1_vld_q  <= s1_vld_d;
            rr_ptr_q  <= rr_ptr_d;
            res_vld_q <= res_vld_d;
            res_sum_q <= res_sum_d;
            res_id_q  <= res_id_d;
            res_sat_q <= res_sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign res_vld = res_vld_q;
    assign res_sum = res_sum_q;
    assign res_id  = res_id_q;
    assign res_sat = res_sat_q;
    assign sat_cnt = sat_cnt_q;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Bench for sat_add_arbiter (N_REQ=4, W=4, CNT_W=8). A transaction-level
// model (round-robin pointer, two-slot pipe of expected results, integer
// saturating arithmetic, saturating counter) is compared every cycle, and
// directed vectors pin literal expectations.
module tb_sat_add_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_vld;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]  req_rdy;
    logic          res_vld;
    logic          res_rdy;
    logic [W-1:0]  res_sum;
    logic [1:0]    res_id;
    logic          res_sat;
    logic [CW-1:0] sat_cnt;
    logic          sat_cnt_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sat_add_arbiter #(
        .N_REQ (N),
        .W     (W),
        .CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_vld     (req_vld),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_rdy     (req_rdy),
        .res_vld     (res_vld),
        .res_rdy     (res_rdy),
        .res_sum     (res_sum),
        .res_id      (res_id),
        .res_sat     (res_sat),
        .sat_cnt     (sat_cnt),
        .sat_cnt_clr (sat_cnt_clr)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         ptr_m;
    bit         p0_v, p1_v;
    logic [3:0] p0_sum, p1_sum;
    int         p0_id, p1_id;
    bit         p0_sat, p1_sat;
    int         cnt_m;

    function automatic int grant_m(input logic [3:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic void sat_add_m(input logic [3:0] a, input logic [3:0] b,
                                      output logic [3:0] s, output bit st);
        int sa, sb, t;
        sa = (a > 7) ? int'(a) - 16 : int'(a);
        sb = (b > 7) ? int'(b) - 16 : int'(b);
        t  = sa + sb;
        if (t > 7) begin
            s = 4'h7; st = 1'b1;
        end else if (t < -8) begin
            s = 4'h8; st = 1'b1;
        end else begin
            s = 4'(t); st = 1'b0;
        end
    endfunction

    // Advance the model on every clock edge; reset clears it like the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_m = 0; p0_v = 0; p1_v = 0; cnt_m = 0;
            p0_sum = 0; p1_sum = 0; p0_id = 0; p1_id = 0; p0_sat = 0; p1_sat = 0;
        end else begin
            bit adv_m, ev;
            int g;
            adv_m = !p1_v || res_rdy;
            ev    = adv_m && p0_v && p0_sat;
            if (sat_cnt_clr) cnt_m = ev ? 1 : 0;
            else if (ev && cnt_m < 255) cnt_m++;
            if (p1_v && res_rdy)
                $display("res id=%0d sum=%h sat=%0d t=%0t", p1_id, p1_sum, p1_sat, $time);
            if (adv_m) begin
                p1_v = p0_v; p1_sum = p0_sum; p1_id = p0_id; p1_sat = p0_sat;
                g = grant_m(req_vld, ptr_m);
                if (g >= 0) begin
                    sat_add_m(req_a[g*W +: W], req_b[g*W +: W], p0_sum, p0_sat);
                    p0_id = g;
                    p0_v  = 1'b1;
                    ptr_m = (g + 1) % N;
                end else begin
                    p0_v = 1'b0;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        int g;
        g = grant_m(req_vld, ptr_m);
        exp_rdy = '0;
        if (g >= 0 && (!p1_v || res_rdy)) exp_rdy = 4'(1 << g);
        chk("m_req_rdy", req_rdy, exp_rdy);
        chk("m_res_vld", res_vld, p1_v);
        if (p1_v) begin
            chk("m_res_sum", res_sum, p1_sum);
            chk("m_res_id",  res_id,  p1_id);
            chk("m_res_sat", res_sat, p1_sat);
        end
        chk("m_sat_cnt", sat_cnt, cnt_m);
    end

    // ---------------- directed stimulus ----------------
    task automatic drive_lane(input int lane, input logic [3:0] a, input logic [3:0] b);
        req_vld[lane]      = 1'b1;
        req_a[lane*W +: W] = a;
        req_b[lane*W +: W] = b;
    endtask

    // Request presented for one cycle; captured at the following edge and
    // visible at the output after the second edge.
    task automatic single_op(input int lane, input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] es, input bit esat, input string nm);
        @(posedge clk); #1;
        drive_lane(lane, a, b);
        @(posedge clk); #1;
        req_vld = '0;
        chk({nm, "_lat"}, res_vld, 1'b0);
        @(posedge clk); #1;
        chk({nm, "_vld"}, res_vld, 1'b1);
        chk({nm, "_sum"}, res_sum, es);
        chk({nm, "_id"},  res_id,  lane);
        chk({nm, "_sat"}, res_sat, esat);
    endtask

    initial begin
        logic [3:0] s_sum;
        logic [1:0] s_id;
        logic       s_sat;
        int         n;

        rst = 1'b1; req_vld = '0; req_a = '0; req_b = '0;
        res_rdy = 1'b1; sat_cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_vld", res_vld, 0);
        chk("rst_sum", res_sum, 0);
        chk("rst_id",  res_id,  0);
        chk("rst_sat", res_sat, 0);
        chk("rst_cnt", sat_cnt, 0);
        chk("rst_rdy", req_rdy, 0);

        // 1: plain add on lane 0
        single_op(0, 4'd3, 4'd2, 4'd5, 1'b0, "t1");

        // 2: saturation corners on lanes 1..3 (pointer returns to 0)
        single_op(1, 4'h7, 4'h1, 4'h7, 1'b1, "t2a");
        single_op(2, 4'h8, 4'hF, 4'h8, 1'b1, "t2b");
        single_op(3, 4'h8, 4'h7, 4'hF, 1'b0, "t2c");
        chk("t2_cnt", sat_cnt, 2);

        // 3: all lanes valid, full throughput, strict rotation
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) drive_lane(i, 4'(i), 4'd1);
        @(posedge clk); #1;
        chk("t3_fill", res_vld, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("t3_vld", res_vld, 1);
            chk("t3_id",  res_id,  i % N);
            chk("t3_sum", res_sum, (i % N) + 1);
        end

        // 4: stall the full pipe for three cycles
        res_rdy = 1'b0;
        #1;
        s_sum = res_sum; s_id = res_id; s_sat = res_sat;
        chk("t4_rdy0", req_rdy, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t4_hold_vld", res_vld, 1);
            chk("t4_hold_sum", res_sum, s_sum);
            chk("t4_hold_id",  res_id,  s_id);
            chk("t4_hold_sat", res_sat, s_sat);
            chk("t4_hold_rdy", req_rdy, 0);
        end
        res_rdy = 1'b1;
        @(posedge clk); #1;
        chk("t4_next_id", res_id, 2'(s_id + 2'd1));
        chk("t4_next_vld", res_vld, 1);

        // 5: asynchronous reset between edges
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("t5_vld", res_vld, 0);
        chk("t5_cnt", sat_cnt, 0);
        @(posedge clk); #3;
        rst = 1'b0;
        req_vld = 4'b0110;
        #1;
        chk("t5_grant", req_rdy, 4'b0010);
        @(posedge clk); #1;
        req_vld = '0;
        repeat (3) @(posedge clk);

        // 6: 260 saturating ops, counter parks at 255
        #1;
        drive_lane(0, 4'h7, 4'h7);
        n = 0;
        for (int c = 0; c < 2000 && n < 260; c++) begin
            @(negedge clk);
            if (req_rdy[0] && req_vld[0]) n++;
        end
        chk("t6_accepts", n, 260);
        @(posedge clk); #1;
        req_vld = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_cnt_max", sat_cnt, 255);
        single_op(0, 4'h7, 4'h7, 4'h7, 1'b1, "t6_more");
        @(posedge clk); #1;
        chk("t6_cnt_hold", sat_cnt, 255);

        // clear coinciding with a saturation event
        drive_lane(0, 4'h7, 4'h7);
        repeat (2) @(posedge clk);
        #1;
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        req_vld = '0;
        chk("t6_clr_evt", sat_cnt, 1);
        repeat (3) @(posedge clk);
        #1;
        sat_cnt_clr = 1'b1;
        @(posedge clk); #1;
        sat_cnt_clr = 1'b0;
        chk("t6_clr_alone", sat_cnt, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
